// File: rtl/move_average_pkg.sv
// Shared types and elaboration helpers for the multi-channel moving-average scheduler.
package move_average_pkg;

    // state   | meaning
    // EMPTY   | no samples in the window since the last clear
    // FILLING | some samples in; the average still contains reset zeros
    // FULL    | the window holds WIN real samples
    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        FILLING = 2'd1,
        FULL    = 2'd2
    } ch_state_t;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

    function automatic int sum_width(input int width, input int ave_log2);
        return width + ave_log2;
    endfunction

    function automatic ch_state_t fill_state(input int fill, input int win);
        if (fill == 0) return EMPTY;
        else if (fill < win) return FILLING;
        else return FULL;
    endfunction

endpackage

// File: rtl/move_average_sched_rr_arbiter.sv
// Round-robin grant among N requesters; the search starts just after the last winner.
module rr_arbiter
    import move_average_pkg::*;
#(
    parameter int N = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_clr,
    input  logic [N-1:0]          i_req,
    input  logic                  i_adv,
    output logic [N-1:0]          o_gnt,
    output logic [clog2(N)-1:0]   o_idx,
    output logic                  o_any
);

    localparam int IW = clog2(N);

    logic [IW-1:0] r_ptr;
    int            w_pos;

    always_comb begin
        o_gnt = '0;
        o_idx = '0;
        o_any = 1'b0;
        w_pos = 0;
        for (int k = 0; k < N; k++) begin
            w_pos = int'(r_ptr) + k;
            if (w_pos >= N) w_pos = w_pos - N;
            if (!o_any && i_req[w_pos[IW-1:0]]) begin
                o_any                = 1'b1;
                o_gnt[w_pos[IW-1:0]] = 1'b1;
                o_idx                = w_pos[IW-1:0];
            end
        end
    end

    // r_ptr is the first channel considered next cycle, not the last winner
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else if (i_clr) begin
            r_ptr <= '0;
        end else if (i_adv && o_any) begin
            r_ptr <= (o_idx == IW'(N - 1)) ? '0 : o_idx + 1'b1;
        end
    end

endmodule

// File: rtl/move_average_sched.sv
// Shares one moving-average adder between NCH sample channels with round-robin grants.
// Build option MOVE_AVG_ROUND_EN: round half up before the divide instead of truncating.
module move_average_sched
    import move_average_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int NCH      = 4,
    parameter int AVE_LOG2 = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      enable,
    input  logic [NCH-1:0]            req_valid,
    input  logic [NCH*WIDTH-1:0]      req_data,
    output logic [NCH-1:0]            req_ready,
    input  logic [NCH-1:0]            flush,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [clog2(NCH)-1:0]     out_chan,
    output logic [WIDTH-1:0]          out_data,
    output logic                      out_warm
);

    localparam int WIN = 1 << AVE_LOG2;
    localparam int CW  = clog2(NCH);
    localparam int SW  = sum_width(WIDTH, AVE_LOG2);
    localparam int FW  = AVE_LOG2 + 1;
`ifdef MOVE_AVG_ROUND_EN
    localparam int RND = (1 << AVE_LOG2) >> 1;
`else
    localparam int RND = 0;
`endif

    logic                 r_live;
    logic [NCH-1:0]       r_pend_valid;
    logic [WIDTH-1:0]     r_pend_data [NCH];
    logic [WIDTH-1:0]     r_win [NCH][WIN];
    logic [FW-1:0]        r_fill [NCH];

    logic                 r_s1_valid;
    logic [CW-1:0]        r_s1_chan;
    logic [WIDTH-1:0]     r_s1_avg;
    logic                 r_s1_warm;

    logic                 r_out_valid;
    logic [CW-1:0]        r_out_chan;
    logic [WIDTH-1:0]     r_out_data;
    logic                 r_out_warm;

    logic                 w_en;
    logic                 w_stall;
    logic                 w_adv;
    logic [NCH-1:0]       w_gnt;
    logic [CW-1:0]        w_gidx;
    logic                 w_gany;
    logic [SW-1:0]        w_sum;
    logic [WIDTH-1:0]     w_avg;
    logic [FW-1:0]        w_new_fill;
    ch_state_t            w_new_state;

    // r_live keeps req_ready low while reset is asserted even if enable is already high
    assign w_en      = enable & r_live;
    assign w_stall   = r_out_valid & ~out_ready;
    assign w_adv     = w_en & ~w_stall;
    assign req_ready = {NCH{w_en}} & ~r_pend_valid;

    rr_arbiter #(.N(NCH)) u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .i_clr (~w_en),
        .i_req (r_pend_valid),
        .i_adv (w_adv),
        .o_gnt (w_gnt),
        .o_idx (w_gidx),
        .o_any (w_gany)
    );

    // Shared adder: sums the granted channel's window as it will look after the shift
    always_comb begin
        w_sum = SW'(r_pend_data[w_gidx]) + SW'(RND);
        for (int k = 0; k < WIN - 1; k++) begin
            w_sum = w_sum + SW'(r_win[w_gidx][k]);
        end
    end

    assign w_avg       = WIDTH'(w_sum >> AVE_LOG2);
    assign w_new_fill  = (r_fill[w_gidx] == FW'(WIN)) ? r_fill[w_gidx] : r_fill[w_gidx] + 1'b1;
    assign w_new_state = fill_state(int'(w_new_fill), WIN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_live <= 1'b0;
        else        r_live <= 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend_valid <= '0;
            for (int i = 0; i < NCH; i++) begin
                r_pend_data[i] <= '0;
                r_fill[i]      <= '0;
                for (int k = 0; k < WIN; k++) r_win[i][k] <= '0;
            end
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (!w_en || flush[i]) begin
                    r_pend_valid[i] <= 1'b0;
                    r_fill[i]       <= '0;
                    for (int k = 0; k < WIN; k++) r_win[i][k] <= '0;
                end else if (w_adv && w_gnt[i]) begin
                    r_pend_valid[i] <= 1'b0;
                    r_fill[i]       <= w_new_fill;
                    r_win[i][0]     <= r_pend_data[i];
                    for (int k = 1; k < WIN; k++) r_win[i][k] <= r_win[i][k-1];
                end else if (req_valid[i] && req_ready[i]) begin
                    r_pend_valid[i] <= 1'b1;
                    r_pend_data[i]  <= req_data[i*WIDTH +: WIDTH];
                end
            end
        end
    end

    // A flush landing on the grant cycle suppresses that result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_chan  <= '0;
            r_s1_avg   <= '0;
            r_s1_warm  <= 1'b0;
        end else if (!w_en) begin
            r_s1_valid <= 1'b0;
        end else if (!w_stall) begin
            r_s1_valid <= w_gany & ~flush[w_gidx];
            r_s1_chan  <= w_gidx;
            r_s1_avg   <= w_avg;
            r_s1_warm  <= (w_new_state != FULL);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_chan  <= '0;
            r_out_data  <= '0;
            r_out_warm  <= 1'b0;
        end else if (!w_stall) begin
            r_out_valid <= r_s1_valid & w_en;
            if (r_s1_valid && w_en) begin
                r_out_chan <= r_s1_chan;
                r_out_data <= r_s1_avg;
                r_out_warm <= r_s1_warm;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_chan  = r_out_chan;
    assign out_data  = r_out_data;
    assign out_warm  = r_out_warm;

endmodule

// File: tb/tb_move_average_sched.sv
// Self-checking bench for move_average_sched; honours MOVE_AVG_ROUND_EN for expected rounding.
module tb_move_average_sched;

    localparam int WIDTH    = 16;
    localparam int NCH      = 4;
    localparam int AVE_LOG2 = 2;
    localparam int WIN      = 1 << AVE_LOG2;
`ifdef MOVE_AVG_ROUND_EN
    localparam int RND = WIN / 2;
`else
    localparam int RND = 0;
`endif

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 enable;
    logic [NCH-1:0]       req_valid;
    logic [NCH*WIDTH-1:0] req_data;
    logic [NCH-1:0]       req_ready;
    logic [NCH-1:0]       flush;
    logic                 out_valid;
    logic                 out_ready;
    logic [1:0]           out_chan;
    logic [WIDTH-1:0]     out_data;
    logic                 out_warm;

    always #5 clk = ~clk;

    move_average_sched #(.WIDTH(WIDTH), .NCH(NCH), .AVE_LOG2(AVE_LOG2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_chan  (out_chan),
        .out_data  (out_data),
        .out_warm  (out_warm)
    );

    typedef struct { int chan; int data; int warm; int cyc; } obs_t;
    typedef struct { int data; int warm; int cyc; } exp_t;

    obs_t        obs_q[$];
    exp_t        exp_q[NCH][$];
    int unsigned hist[NCH][$];
    int          cyc = 0;
    int          errors = 0;
    int          checks = 0;

    // Reference: the window is just the last WIN accepted samples, missing ones count as zero
    function automatic exp_t model_push(input int ch, input int unsigned d);
        exp_t        e;
        int unsigned s;
        s = 0;
        hist[ch].push_front(d);
        if (hist[ch].size() > WIN) void'(hist[ch].pop_back());
        for (int j = 0; j < hist[ch].size(); j++) s += hist[ch][j];
        e.data = int'((s + RND) >> AVE_LOG2);
        e.warm = (hist[ch].size() < WIN) ? 1 : 0;
        e.cyc  = cyc;
        return e;
    endfunction

    always @(posedge clk) begin
        obs_t o;
        if (rst_n) begin
            if (out_valid && out_ready) begin
                o.chan = int'(out_chan);
                o.data = int'(out_data);
                o.warm = int'(out_warm);
                o.cyc  = cyc;
                obs_q.push_back(o);
            end
            for (int i = 0; i < NCH; i++) begin
                if (!enable || flush[i]) hist[i].delete();
                else if (req_valid[i] && req_ready[i])
                    exp_q[i].push_back(model_push(i, int'(req_data[i*WIDTH +: WIDTH])));
            end
        end
        cyc++;
    end

    always @(negedge rst_n) begin
        for (int i = 0; i < NCH; i++) hist[i].delete();
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input int ch, input int d);
        req_valid[ch] = 1'b1;
        req_data[ch*WIDTH +: WIDTH] = WIDTH'(d);
        tick(1);
        req_valid[ch] = 1'b0;
    endtask

    task automatic wait_obs(input int n);
        for (int k = 0; k < 60 && obs_q.size() < n; k++) tick(1);
    endtask

    task automatic clear_queues;
        obs_q.delete();
        for (int i = 0; i < NCH; i++) exp_q[i].delete();
    endtask

    task automatic clear_all;
        out_ready = 1'b1;
        req_valid = '0;
        flush     = '0;
        tick(4);
        enable = 1'b0;
        tick(1);
        enable = 1'b1;
        tick(1);
        clear_queues();
    endtask

    task automatic test_reset;
        rst_n = 1'b0; enable = 1'b1; out_ready = 1'b1;
        req_valid = '0; req_data = '0; flush = '0;
        tick(2);
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_req_ready: got %b expected 0000", req_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++; if (out_chan !== 2'd0) begin errors++; $display("FAIL reset_out_chan: got %0d expected 0", out_chan); end
        checks++; if (out_data !== 16'd0) begin errors++; $display("FAIL reset_out_data: got %0d expected 0", out_data); end
        checks++; if (out_warm !== 1'b0) begin errors++; $display("FAIL reset_out_warm: got %b expected 0", out_warm); end
        rst_n = 1'b1;
        tick(2);
        checks++; if (req_ready !== 4'b1111) begin errors++; $display("FAIL post_reset_ready: got %b expected 1111", req_ready); end
    endtask

    task automatic test_fill;
        int   vals[5]   = '{4, 8, 12, 16, 20};
        int   spec_d[5] = '{1, 3, 6, 10, 14};
        int   spec_w[5] = '{1, 1, 1, 0, 0};
        obs_t o;
        exp_t e;
        clear_all();
        for (int k = 0; k < 5; k++) begin
            send(0, vals[k]);
            tick(3);
        end
        wait_obs(5);
        checks++; if (obs_q.size() != 5) begin errors++; $display("FAIL fill_count: got %0d expected 5", obs_q.size()); end
        for (int k = 0; k < 5 && obs_q.size() > 0 && exp_q[0].size() > 0; k++) begin
            o = obs_q.pop_front();
            e = exp_q[0].pop_front();
            checks++; if (o.chan != 0) begin errors++; $display("FAIL fill_chan[%0d]: got %0d expected 0", k, o.chan); end
            checks++; if (o.data != spec_d[k]) begin errors++; $display("FAIL fill_data[%0d]: got %0d expected %0d", k, o.data, spec_d[k]); end
            checks++; if (o.warm != spec_w[k]) begin errors++; $display("FAIL fill_warm[%0d]: got %0d expected %0d", k, o.warm, spec_w[k]); end
            // valid two edges after acceptance, taken by the handshake on the third
            checks++; if (o.cyc - e.cyc != 3) begin errors++; $display("FAIL fill_latency[%0d]: got %0d expected 3", k, o.cyc - e.cyc); end
        end
    endtask

    task automatic test_round_robin;
        obs_t o;
        int   acc;
        clear_all();
        req_data  = {16'd400, 16'd300, 16'd200, 16'd100};
        req_valid = 4'b1111;
        tick(1);
        req_valid = '0;
        acc = (exp_q[0].size() > 0) ? exp_q[0][0].cyc : -100;
        wait_obs(4);
        checks++; if (obs_q.size() != 4) begin errors++; $display("FAIL rr_count: got %0d expected 4", obs_q.size()); end
        for (int k = 0; k < 4 && obs_q.size() > 0; k++) begin
            o = obs_q.pop_front();
            checks++; if (o.chan != k) begin errors++; $display("FAIL rr_chan[%0d]: got %0d expected %0d", k, o.chan, k); end
            checks++; if (o.data != 25 * (k + 1)) begin errors++; $display("FAIL rr_data[%0d]: got %0d expected %0d", k, o.data, 25 * (k + 1)); end
            checks++; if (o.cyc != acc + 3 + k) begin errors++; $display("FAIL rr_cycle[%0d]: got %0d expected %0d", k, o.cyc, acc + 3 + k); end
        end
    endtask

    task automatic test_stall;
        int   chans[3] = '{0, 1, 2};
        int   datas[3] = '{250, 50, 75};
        obs_t o;
        clear_all();
        out_ready = 1'b0;
        send(0, 1000);
        tick(4);
        req_data[1*WIDTH +: WIDTH] = 16'd200;
        req_data[2*WIDTH +: WIDTH] = 16'd300;
        req_valid = 4'b0110;
        tick(1);
        req_valid = '0;
        for (int k = 0; k < 5; k++) begin
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL stall_valid[%0d]: got %b expected 1", k, out_valid); end
            checks++; if (out_chan !== 2'd0 || out_data !== 16'd250) begin errors++; $display("FAIL stall_hold[%0d]: got chan %0d data %0d expected chan 0 data 250", k, out_chan, out_data); end
            checks++; if (req_ready[2:1] !== 2'b00) begin errors++; $display("FAIL stall_ready[%0d]: got %b expected 00", k, req_ready[2:1]); end
            tick(1);
        end
        out_ready = 1'b1;
        wait_obs(3);
        tick(2);
        checks++; if (obs_q.size() != 3) begin errors++; $display("FAIL stall_count: got %0d expected 3", obs_q.size()); end
        for (int k = 0; k < 3 && obs_q.size() > 0; k++) begin
            o = obs_q.pop_front();
            checks++; if (o.chan != chans[k] || o.data != datas[k]) begin errors++; $display("FAIL stall_resume[%0d]: got chan %0d data %0d expected chan %0d data %0d", k, o.chan, o.data, chans[k], datas[k]); end
        end
    endtask

    task automatic test_flush;
        int   datas[5] = '{10, 20, 30, 40, 20};
        int   warms[5] = '{1, 1, 1, 0, 1};
        obs_t o;
        clear_all();
        for (int k = 0; k < 4; k++) begin
            send(0, 40);
            tick(3);
        end
        send(0, 80);
        flush[0] = 1'b1;
        tick(1);
        flush[0] = 1'b0;
        tick(3);
        send(0, 80);
        wait_obs(5);
        tick(4);
        checks++; if (obs_q.size() != 5) begin errors++; $display("FAIL flush_count: got %0d expected 5", obs_q.size()); end
        for (int k = 0; k < 5 && obs_q.size() > 0; k++) begin
            o = obs_q.pop_front();
            checks++; if (o.data != datas[k] || o.warm != warms[k]) begin errors++; $display("FAIL flush_out[%0d]: got data %0d warm %0d expected data %0d warm %0d", k, o.data, o.warm, datas[k], warms[k]); end
        end
    endtask

    task automatic test_rounding;
        int   vals[4] = '{1, 1, 0, 0};
        obs_t o;
        int   want;
        want = (RND != 0) ? 1 : 0;
        clear_all();
        for (int k = 0; k < 4; k++) begin
            send(3, vals[k]);
            tick(3);
        end
        wait_obs(4);
        checks++; if (obs_q.size() != 4) begin errors++; $display("FAIL round_count: got %0d expected 4", obs_q.size()); end
        while (obs_q.size() > 1) void'(obs_q.pop_front());
        if (obs_q.size() == 1) begin
            o = obs_q.pop_front();
            checks++; if (o.chan != 3) begin errors++; $display("FAIL round_chan: got %0d expected 3", o.chan); end
            checks++; if (o.data != want || o.warm != 0) begin errors++; $display("FAIL round_final: got data %0d warm %0d expected data %0d warm 0", o.data, o.warm, want); end
        end
    endtask

    task automatic load_pending;
        clear_all();
        out_ready = 1'b0;
        send(0, 500);
        tick(4);
        req_data[1*WIDTH +: WIDTH] = 16'd123;
        req_data[2*WIDTH +: WIDTH] = 16'd456;
        req_valid = 4'b0110;
        tick(1);
        req_valid = '0;
    endtask

    task automatic check_restart(input string tag);
        obs_t o;
        clear_queues();
        out_ready = 1'b1;
        send(0, 8);
        wait_obs(1);
        checks++; if (obs_q.size() != 1) begin errors++; $display("FAIL %s_restart_count: got %0d expected 1", tag, obs_q.size()); end
        if (obs_q.size() > 0) begin
            o = obs_q.pop_front();
            checks++; if (o.chan != 0 || o.data != 2 || o.warm != 1) begin errors++; $display("FAIL %s_restart: got chan %0d data %0d warm %0d expected chan 0 data 2 warm 1", tag, o.chan, o.data, o.warm); end
        end
    endtask

    task automatic test_enable_drop;
        load_pending();
        enable    = 1'b0;
        out_ready = 1'b1;
        tick(1);
        for (int k = 0; k < 4; k++) begin
            checks++; if (req_ready !== 4'b0000 || out_valid !== 1'b0) begin errors++; $display("FAIL endrop[%0d]: got ready %b valid %b expected ready 0000 valid 0", k, req_ready, out_valid); end
            tick(1);
        end
        enable = 1'b1;
        tick(2);
        check_restart("endrop");
    endtask

    task automatic test_reset_midstream;
        load_pending();
        rst_n = 1'b0;
        #1;
        checks++; if (req_ready !== 4'b0000 || out_valid !== 1'b0) begin errors++; $display("FAIL midreset: got ready %b valid %b expected ready 0000 valid 0", req_ready, out_valid); end
        tick(2);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        tick(3);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midreset_idle: got valid %b expected 0", out_valid); end
        check_restart("midreset");
    endtask

    task automatic test_random;
        obs_t o;
        exp_t e;
        int   total;
        clear_all();
        for (int c = 0; c < 400; c++) begin
            req_valid = NCH'($urandom_range(0, 15));
            for (int i = 0; i < NCH; i++) req_data[i*WIDTH +: WIDTH] = WIDTH'($urandom_range(0, 65535));
            out_ready = ($urandom_range(0, 3) != 0);
            tick(1);
        end
        req_valid = '0;
        out_ready = 1'b1;
        total = 0;
        for (int i = 0; i < NCH; i++) total += exp_q[i].size();
        wait_obs(total);
        tick(3);
        checks++; if (obs_q.size() != total) begin errors++; $display("FAIL rand_count: got %0d expected %0d", obs_q.size(), total); end
        while (obs_q.size() > 0) begin
            o = obs_q.pop_front();
            checks++;
            if (exp_q[o.chan].size() == 0) begin
                errors++; $display("FAIL rand_extra: got output on chan %0d expected none", o.chan);
            end else begin
                e = exp_q[o.chan].pop_front();
                if (o.data != e.data || o.warm != e.warm) begin
                    errors++; $display("FAIL rand_out chan %0d: got data %0d warm %0d expected data %0d warm %0d", o.chan, o.data, o.warm, e.data, e.warm);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_round_robin();
        test_stall();
        test_flush();
        test_rounding();
        test_enable_drop();
        test_reset_midstream();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/move_average_sched.md
# move_average_sched

Round-robin scheduler that shares one 4-sample moving-average adder tree between `NCH` independent sample channels, e.g. per-phase motor speed or encoder-period streams. Each channel owns its window history and fill state. The block arbitrates which channel's new sample goes into the shared sum each cycle, and emits channel-tagged averages with output backpressure. It sits between the motor measurement front-ends and the speed control loop.

## Interface
- `WIDTH`, 16, sample and average width (unsigned)
- `NCH`, 4, number of channels, 2..8
- `AVE_LOG2`, 2, log2 of window length; `WIN = 1<<AVE_LOG2`, range 1..4

- `clk` in 1: clock
- `rst_n` in 1: reset, asynchronous, active-low
- `enable` in 1: level; low clears all channel state and blocks acceptance
- `req_valid` in NCH: per-channel sample valid
- `req_data` in NCH*WIDTH: channel i sample at `[i*WIDTH +: WIDTH]`
- `req_ready` out NCH: per-channel accept
- `flush` in NCH: per-channel pulse; clears that channel's window
- `out_valid` out 1: average valid
- `out_ready` in 1: downstream accept
- `out_chan` out clog2(NCH): channel of `out_data`
- `out_data` out WIDTH: `sum(window) >> AVE_LOG2`
- `out_warm` out 1: channel window not yet full when this average was computed

## Operation
- Per channel state:
  - pending register `pend_valid`/`pend_data`
  - window of WIN samples
  - fill counter 0..WIN, saturating
  - state EMPTY (fill 0), FILLING (0<fill<WIN), FULL (fill=WIN)
- `req_ready[i] = enable & ~pend_valid[i]`. A sample is accepted on `req_valid[i] & req_ready[i]`.
- Arbiter, stage G:
  - Among channels with `pend_valid`, grant exactly one per cycle, round-robin starting after the last granted channel. The pointer resets to channel 0.
  - A grant shifts `pend_data` into that channel's window (oldest sample drops), increments fill, clears `pend_valid`, and loads `s1_valid`/`s1_chan`.
- Stage O:
  - Sums the granted channel's updated window, width `WIDTH+AVE_LOG2`, no overflow.
  - Registers `out_data` as `sum[WIDTH+AVE_LOG2-1:AVE_LOG2]`, plus `out_chan`, and `out_warm = (fill < WIN)` after the update.
- Windows reset to zero. During FILLING the average therefore includes zeros and is still divided by WIN.
- Stall:
  - When `out_valid & ~out_ready`, hold `out_*` and stage G, and issue no grants.
  - Pending registers keep their data, so `req_ready` stays low for pending channels.
- Flush of channel i:
  - Zeroes its window and fill, and discards its pending sample.
  - If the same cycle also grants i, flush wins and no `s1_valid` is produced for i.
  - An in-flight O result for i still completes.
- `enable` low:
  - Same effect as a flush on all channels, plus the pointer returns to 0.
  - `out_valid` drops after the current output is accepted. No new outputs are produced.
- Reset values: `req_ready` 0, `out_valid` 0, `out_chan` 0, `out_data` 0, `out_warm` 0. All windows, fills, pendings and the pointer are 0.

## Timing
- Accept at edge E0, grant in the next cycle, window update at E1, `out_valid` at E2. Latency is 2 cycles with no contention.
- Throughput: one average per cycle aggregate. With all NCH channels pending, each is served once every NCH cycles.
- A channel can accept a new sample in the cycle after its grant.
- Asynchronous reset mid-stream drops all pending and in-flight data immediately.

## Configuration
- `MOVE_AVG_ROUND_EN` defined: add `1<<(AVE_LOG2-1)` to the sum before the shift (round half up). If `AVE_LOG2=0`, add nothing.
- Undefined: truncate, i.e. shift only.

## Structure
- Shared package `move_average_pkg`:
  - `ch_state_t` enum (EMPTY, FILLING, FULL)
  - sum-width constant function
  - `clog2` function
- Sub-module `rr_arbiter`:
  - parameter N
  - inputs: request vector, advance strobe
  - outputs: one-hot grant, grant index
  - owns the round-robin pointer

## Test plan
- WIDTH=16, NCH=4, AVE_LOG2=2, truncation; ch0 samples 4, 8, 12, 16, 20 → `out_data` 1, 3, 6, 10, 14; `out_warm` 1, 1, 1, 0, 0; each output 2 cycles after acceptance.
- All four channels present 100, 200, 300, 400 in the same cycle → `out_chan` 0, 1, 2, 3 on consecutive cycles; data 25, 50, 75, 100.
- `out_ready` held low for 5 cycles with ch1 and ch2 pending → `out_*` stable, no grants, `req_ready[1:2]` low; on release, outputs resume in round-robin order with none lost.
- ch0 FULL with 40, 40, 40, 40; `flush[0]` in the same cycle as ch0's grant of 80 → no output for that sample; next sample 80 → `out_data` 20, `out_warm` 1.
- Samples 1, 1, 0, 0 on ch3: with `MOVE_AVG_ROUND_EN` final `out_data` = 1; without it, 0.
- Drop `enable` or assert `rst_n` mid-stream with pendings present → `req_ready` = 0, no further `out_valid`; after re-enable, ch0 sample 8 → `out_data` 2, `out_warm` 1.
